// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit : multi-cycle restoring integer divider (signed/unsigned) for EX
// Rev 1.0  : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH:0]     work_q, work_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH-1:0]     op1_abs, op2_abs;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     quo, rem;

  assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign diff    = work_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};
  // After WIDTH steps the quotient sits in the low half; the remainder was
  // shifted once past the padding bit that started at bit 0.
  assign quo     = work_q[WIDTH-1:0];
  assign rem     = work_q[2*WIDTH:WIDTH+1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          divisor_d = op2_abs;
          work_d    = {{WIDTH{1'b0}}, op1_abs, 1'b0};
          qneg_d    = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          rneg_d    = signed_div_i & opdata1_i[WIDTH-1];
          cnt_d     = '0;
          state_d   = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        state_d  = S_END;
        result_d = '0;
        ready_d  = 1'b1;
      end
      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q == CW'(WIDTH)) begin
          result_d = {(rneg_q ? -rem : rem), (qneg_q ? -quo : quo)};
          ready_d  = 1'b1;
          state_d  = S_END;
        end else begin
          if (diff[WIDTH]) begin
            work_d = {work_q[2*WIDTH-1:0], 1'b0};
          end else begin
            work_d = {diff[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit : randomized self-checking bench for div_unit with a
//               transaction-level reference model
// Rev 1.0     : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: {remainder, quotient}, zero for divide-by-zero.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: accepted request -> result after a fixed delay.
  bit          m_busy = 0;
  bit          m_zero = 0;
  int          m_wait = 0;
  bit          m_ready = 0;
  logic [63:0] m_result = '0;
  logic [63:0] m_pending = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   = 0;
      m_ready  = 0;
      m_result = '0;
    end else if (m_ready) begin
      if (!start_i || annul_i) begin
        m_ready  = 0;
        m_result = '0;
      end
    end else if (m_busy) begin
      if (annul_i && !m_zero) begin
        m_busy = 0;
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          m_busy   = 0;
          m_ready  = 1;
          m_result = m_pending;
        end
      end
    end else if (start_i && !annul_i) begin
      m_busy    = 1;
      m_zero    = (opdata2_i == 32'd0);
      m_wait    = m_zero ? 1 : 33;
      m_pending = ref_div(signed_div_i, opdata1_i, opdata2_i);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_ready", {63'd0, ready_o}, {63'd0, m_ready});
      chk("model_result", result_o, m_result);
    end
  end

  // Called at the drive point (#1 after a rising edge).
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit scramble, input bit drop,
                         output logic [63:0] res, output int lat);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        lat = n;
        break;
      end
      if (scramble) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
    end
    if (lat < 0) chk("ready_timeout", 64'd0, 64'd1);
    res = result_o;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("held_ready", {63'd0, ready_o}, 64'd1);
      chk("held_result", result_o, res);
    end
    if (drop) begin
      start_i = 1'b0;
      @(posedge clk); #1;
      chk("drop_ready", {63'd0, ready_o}, 64'd0);
      chk("drop_result", result_o, 64'd0);
    end
  endtask

  task automatic idle_no_ready(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [63:0] res;
    int          lat;
    logic [31:0] a, b;
    bit          s;

    repeat (2) @(negedge clk);
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_div(0, 32'd100, 32'd7, 0, 0, 1, res, lat);
    chk("udiv_latency", 64'(lat), 64'd33);
    chk("udiv_result", res, 64'h00000002_0000000E);

    run_div(1, 32'hFFFFFFF9, 32'd2, 0, 0, 1, res, lat);
    chk("sdiv_neg_pos", res, 64'hFFFFFFFF_FFFFFFFD);
    run_div(1, 32'd7, 32'hFFFFFFFE, 0, 0, 1, res, lat);
    chk("sdiv_pos_neg", res, 64'h00000001_FFFFFFFD);
    run_div(1, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, res, lat);
    chk("sdiv_overflow", res, 64'h00000000_80000000);

    run_div(0, 32'd1234, 32'd0, 0, 0, 1, res, lat);
    chk("divzero_u_latency", 64'(lat), 64'd1);
    chk("divzero_u_result", res, 64'd0);
    run_div(1, 32'd1234, 32'd0, 0, 0, 1, res, lat);
    chk("divzero_s_latency", 64'(lat), 64'd1);
    chk("divzero_s_result", res, 64'd0);

    // Flush at cnt==10: accepted on the first edge, ten steps on the next ten.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    idle_no_ready("annul_on_no_ready", 40);
    run_div(0, 32'd9, 32'd3, 0, 0, 1, res, lat);
    chk("after_annul_result", res, 64'h00000000_00000003);
    chk("after_annul_latency", 64'(lat), 64'd33);

    start_i = 1'b1;
    annul_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    idle_no_ready("annul_free_no_accept", 40);

    // Asynchronous reset in the middle of a divide.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_on_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_on_result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_div(0, 32'd100, 32'd7, 0, 0, 1, res, lat);
    chk("post_rst_result", res, 64'h00000002_0000000E);
    chk("post_rst_latency", 64'(lat), 64'd33);

    // Asynchronous reset while a result is presented.
    run_div(0, 32'd50, 32'd6, 0, 0, 0, res, lat);
    chk("pre_rst_end_result", res, 64'h00000002_00000008);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_end_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_div(1, 32'hFFFFFF9C, 32'd7, 0, 1, 1, res, lat);
    chk("operand_stable", res, 64'hFFFFFFFE_FFFFFFF2);

    run_div(0, 32'd100, 32'd7, 5, 0, 1, res, lat);
    chk("held_value", res, 64'h00000002_0000000E);

    for (int i = 0; i < 250; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFFFFFF;
        3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        4: b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(s, a, b, $urandom_range(0, 3), 1'($urandom), 1, res, lat);
      chk("rand_result", res, ref_div(s, a, b));
      chk("rand_latency", 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
